// File: rtl/rs_bank.sv
// rs_bank: parametrised Tomasulo reservation-station bank with CDB snooping and valid/ready issue.
// Define RS_AGE_ORDER_EN for oldest-ready-first selection; default is lowest-index-ready-first.
module rs_bank #(
  parameter int NUM_ENTRIES = 3,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int OP_W        = 4,
  parameter int NUM_CDB     = 6,
  parameter int BASE_TAG    = 7
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  output logic [TAG_W-1:0]                  alloc_tag,
  input  logic [OP_W-1:0]                   alloc_op,
  input  logic [TAG_W-1:0]                  alloc_qj,
  input  logic [TAG_W-1:0]                  alloc_qk,
  input  logic [DATA_W-1:0]                 alloc_vj,
  input  logic [DATA_W-1:0]                 alloc_vk,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]          cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]         cdb_data,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [OP_W-1:0]                   issue_op,
  output logic [DATA_W-1:0]                 issue_vj,
  output logic [DATA_W-1:0]                 issue_vk,
  output logic [TAG_W-1:0]                  issue_tag,
  output logic [NUM_ENTRIES-1:0]            busy_vec,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]  occupancy
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0]             r_busy;
  logic [NUM_ENTRIES-1:0][OP_W-1:0]   r_op;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] r_vj;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] r_vk;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0]  r_qj;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0]  r_qk;
  logic                               r_lock;
  logic [IDX_W-1:0]                   r_lockIdx;

  logic [NUM_ENTRIES-1:0]             w_rdy;
  logic [NUM_ENTRIES-1:0][DATA_W:0]   w_capJ;
  logic [NUM_ENTRIES-1:0][DATA_W:0]   w_capK;
  logic [DATA_W:0]                    w_byJ;
  logic [DATA_W:0]                    w_byK;
  logic [IDX_W-1:0]                   w_allocIdx;
  logic [IDX_W-1:0]                   w_pickIdx;
  logic                               w_pickValid;
  logic [IDX_W-1:0]                   w_selIdx;
  logic                               w_selValid;
  logic [OCC_W-1:0]                   w_occ;
  logic                               w_allocFire;
  logic                               w_issueFire;

  // Returns {hit, data}; the lowest-numbered matching channel wins, tag 0 never matches.
  function automatic logic [DATA_W:0] cdbLookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        valid,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (valid[c] && (tag != '0) && (tags[c*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, data[c*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  always_comb begin
    w_rdy  = '0;
    w_capJ = '0;
    w_capK = '0;
    w_occ  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_rdy[i]  = r_busy[i] && (r_qj[i] == '0) && (r_qk[i] == '0);
      w_capJ[i] = cdbLookup(r_qj[i], cdb_valid, cdb_tag, cdb_data);
      w_capK[i] = cdbLookup(r_qk[i], cdb_valid, cdb_tag, cdb_data);
      w_occ     = w_occ + OCC_W'(r_busy[i]);
    end
    w_byJ = cdbLookup(alloc_qj, cdb_valid, cdb_tag, cdb_data);
    w_byK = cdbLookup(alloc_qk, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    w_allocIdx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_allocIdx = IDX_W'(i);
    end
  end

`ifdef RS_AGE_ORDER_EN
  // r_age[i][j] set means entry j was allocated before entry i and is still busy.
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_age;

  always_comb begin
    w_pickValid = 1'b0;
    w_pickIdx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_rdy[i] && ((r_age[i] & w_rdy) == '0)) begin
        w_pickValid = 1'b1;
        w_pickIdx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else if (flush) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (w_allocFire && (w_allocIdx == IDX_W'(i))) begin
            r_age[i][j] <= r_busy[j] && !(w_issueFire && (w_selIdx == IDX_W'(j)));
          end else if (w_issueFire && ((w_selIdx == IDX_W'(i)) || (w_selIdx == IDX_W'(j)))) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end
`else
  always_comb begin
    w_pickValid = 1'b0;
    w_pickIdx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_pickValid = 1'b1;
        w_pickIdx   = IDX_W'(i);
      end
    end
  end
`endif

  assign w_selIdx    = r_lock ? r_lockIdx : w_pickIdx;
  assign w_selValid  = r_lock | w_pickValid;
  assign w_allocFire = alloc_valid && alloc_ready;
  assign w_issueFire = w_selValid && issue_ready;

  assign alloc_ready = (w_occ < OCC_W'(NUM_ENTRIES));
  assign alloc_tag   = TAG_W'(BASE_TAG) + TAG_W'(w_allocIdx);
  assign busy_vec    = r_busy;
  assign occupancy   = w_occ;

  // Issue fields are forced to zero when nothing is presented.
  assign issue_valid = w_selValid;
  assign issue_op    = w_selValid ? r_op[w_selIdx] : '0;
  assign issue_vj    = w_selValid ? r_vj[w_selIdx] : '0;
  assign issue_vk    = w_selValid ? r_vk[w_selIdx] : '0;
  assign issue_tag   = w_selValid ? (TAG_W'(BASE_TAG) + TAG_W'(w_selIdx)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_op      <= '0;
      r_vj      <= '0;
      r_vk      <= '0;
      r_qj      <= '0;
      r_qk      <= '0;
      r_lock    <= 1'b0;
      r_lockIdx <= '0;
    end else if (flush) begin
      r_busy <= '0;
      r_lock <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (r_busy[i] && w_capJ[i][DATA_W]) begin
          r_vj[i] <= w_capJ[i][DATA_W-1:0];
          r_qj[i] <= '0;
        end
        if (r_busy[i] && w_capK[i][DATA_W]) begin
          r_vk[i] <= w_capK[i][DATA_W-1:0];
          r_qk[i] <= '0;
        end
      end
      if (w_issueFire) r_busy[w_selIdx] <= 1'b0;
      if (w_allocFire) begin
        r_busy[w_allocIdx] <= 1'b1;
        r_op[w_allocIdx]   <= alloc_op;
        r_vj[w_allocIdx]   <= w_byJ[DATA_W] ? w_byJ[DATA_W-1:0] : alloc_vj;
        r_qj[w_allocIdx]   <= w_byJ[DATA_W] ? '0 : alloc_qj;
        r_vk[w_allocIdx]   <= w_byK[DATA_W] ? w_byK[DATA_W-1:0] : alloc_vk;
        r_qk[w_allocIdx]   <= w_byK[DATA_W] ? '0 : alloc_qk;
      end
      r_lock    <= w_selValid && !issue_ready;
      r_lockIdx <= w_selIdx;
    end
  end

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed scenarios plus randomized traffic against an entry-level
// behavioural model of the reservation-station bank (allocation order kept as sequence numbers).
module tb_rs_bank;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int OW = 4;
  localparam int NC = 6;
  localparam int BT = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TW-1:0]     alloc_tag;
  logic [OW-1:0]     alloc_op;
  logic [TW-1:0]     alloc_qj;
  logic [TW-1:0]     alloc_qk;
  logic [DW-1:0]     alloc_vj;
  logic [DW-1:0]     alloc_vk;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [OW-1:0]     issue_op;
  logic [DW-1:0]     issue_vj;
  logic [DW-1:0]     issue_vk;
  logic [TW-1:0]     issue_tag;
  logic [N-1:0]      busy_vec;
  logic [1:0]        occupancy;

  rs_bank #(
    .NUM_ENTRIES(N), .DATA_W(DW), .TAG_W(TW), .OP_W(OW), .NUM_CDB(NC), .BASE_TAG(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_op(alloc_op), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_tag(issue_tag),
    .busy_vec(busy_vec), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one record per station plus the allocation sequence for age order.
  bit            mBusy [N];
  logic [OW-1:0] mOp   [N];
  logic [DW-1:0] mVj   [N];
  logic [DW-1:0] mVk   [N];
  logic [TW-1:0] mQj   [N];
  logic [TW-1:0] mQk   [N];
  int            mSeq  [N];
  int            seqCtr;
  bit            mLock;
  int            mLockIdx;
  bit            expValid;
  int            expSel;

`ifdef RS_AGE_ORDER_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < N; i++) begin
      mBusy[i] = 1'b0; mOp[i] = '0; mVj[i] = '0; mVk[i] = '0;
      mQj[i] = '0; mQk[i] = '0; mSeq[i] = 0;
    end
    mLock = 1'b0;
    mLockIdx = 0;
    seqCtr = 0;
  endfunction

  function automatic bit cdbFind(input logic [TW-1:0] t, output logic [DW-1:0] d);
    d = '0;
    if (t == '0) return 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (cdb_valid[c] && (cdb_tag[c*TW +: TW] == t)) begin
        d = cdb_data[c*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int modelOcc();
    int occ = 0;
    for (int i = 0; i < N; i++) occ += int'(mBusy[i]);
    return occ;
  endfunction

  function automatic int modelFree();
    for (int i = 0; i < N; i++) if (!mBusy[i]) return i;
    return 0;
  endfunction

  function automatic void computeExpected();
    expValid = 1'b0;
    expSel   = 0;
    if (mLock) begin
      expValid = 1'b1;
      expSel   = mLockIdx;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mBusy[i] && mQj[i] == '0 && mQk[i] == '0) begin
          if (!expValid || (AGE && mSeq[i] < mSeq[expSel])) begin
            expValid = 1'b1;
            expSel   = i;
          end
        end
      end
    end
  endfunction

  task automatic checkAll();
    logic [N-1:0] bv;
    int occ;
    computeExpected();
    occ = modelOcc();
    for (int i = 0; i < N; i++) bv[i] = mBusy[i];
    checkOutput("alloc_ready", 64'(alloc_ready), 64'(occ < N));
    checkOutput("alloc_tag",   64'(alloc_tag),   64'(BT + modelFree()));
    checkOutput("occupancy",   64'(occupancy),   64'(occ));
    checkOutput("busy_vec",    64'(busy_vec),    64'(bv));
    checkOutput("issue_valid", 64'(issue_valid), 64'(expValid));
    checkOutput("issue_op",    64'(issue_op),    expValid ? 64'(mOp[expSel]) : 64'(0));
    checkOutput("issue_vj",    64'(issue_vj),    expValid ? 64'(mVj[expSel]) : 64'(0));
    checkOutput("issue_vk",    64'(issue_vk),    expValid ? 64'(mVk[expSel]) : 64'(0));
    checkOutput("issue_tag",   64'(issue_tag),   expValid ? 64'(BT + expSel) : 64'(0));
  endtask

  task automatic modelUpdate();
    logic [DW-1:0] d;
    bit allocOk;
    int freeIdx;
    allocOk = alloc_valid && (modelOcc() < N);
    freeIdx = modelFree();
    if (flush) begin
      for (int i = 0; i < N; i++) mBusy[i] = 1'b0;
      mLock = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (mBusy[i] && cdbFind(mQj[i], d)) begin mVj[i] = d; mQj[i] = '0; end
      if (mBusy[i] && cdbFind(mQk[i], d)) begin mVk[i] = d; mQk[i] = '0; end
    end
    if (expValid && issue_ready) mBusy[expSel] = 1'b0;
    mLock    = expValid && !issue_ready;
    mLockIdx = expSel;
    if (allocOk) begin
      mBusy[freeIdx] = 1'b1;
      mOp[freeIdx]   = alloc_op;
      if (cdbFind(alloc_qj, d)) begin mVj[freeIdx] = d; mQj[freeIdx] = '0; end
      else begin mVj[freeIdx] = alloc_vj; mQj[freeIdx] = alloc_qj; end
      if (cdbFind(alloc_qk, d)) begin mVk[freeIdx] = d; mQk[freeIdx] = '0; end
      else begin mVk[freeIdx] = alloc_vk; mQk[freeIdx] = alloc_qk; end
      mSeq[freeIdx] = seqCtr;
      seqCtr++;
    end
  endtask

  // Entered at posedge+1 with inputs driven; checks mid-cycle, then advances the model at the edge.
  task automatic stepCycle();
    #3;
    checkAll();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic clearInputs();
    flush = 1'b0; alloc_valid = 1'b0; alloc_op = '0;
    alloc_qj = '0; alloc_qk = '0; alloc_vj = '0; alloc_vk = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
  endtask

  task automatic setAlloc(input logic [OW-1:0] op, input logic [TW-1:0] qj, input logic [DW-1:0] vj,
                          input logic [TW-1:0] qk, input logic [DW-1:0] vk);
    alloc_valid = 1'b1; alloc_op = op;
    alloc_qj = qj; alloc_vj = vj; alloc_qk = qk; alloc_vk = vk;
  endtask

  task automatic setCdb(input int c, input logic [TW-1:0] t, input logic [DW-1:0] d);
    cdb_valid[c] = 1'b1;
    cdb_tag[c*TW +: TW] = t;
    cdb_data[c*DW +: DW] = d;
  endtask

  function automatic logic [TW-1:0] pickTag();
    if ($urandom_range(0, 9) < 5) return '0;
    return TW'($urandom_range(1, 15));
  endfunction

  task automatic applyStimulus();
    clearInputs();
    if ($urandom_range(0, 99) < 50)
      setAlloc(OW'($urandom_range(0, 15)), pickTag(), $urandom, pickTag(), $urandom);
    for (int c = 0; c < NC; c++)
      if ($urandom_range(0, 99) < 30) setCdb(c, TW'($urandom_range(1, 15)), $urandom);
    issue_ready = ($urandom_range(0, 99) < 60);
    flush = ($urandom_range(0, 99) < 2);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    #2;
    checkOutput("rst_busy_vec", 64'(busy_vec), 64'(0));
    checkOutput("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    checkOutput("rst_alloc_tag", 64'(alloc_tag), 64'(7));
    checkOutput("rst_issue_valid", 64'(issue_valid), 64'(0));
    checkOutput("rst_issue_tag", 64'(issue_tag), 64'(0));
    checkAll();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Ready operands issue one cycle after allocation.
    setAlloc(4'd1, 4'd0, 32'd5, 4'd0, 32'd9);
    #2 checkOutput("tp1_alloc_tag", 64'(alloc_tag), 64'(7));
    stepCycle();
    clearInputs();
    #2;
    checkOutput("tp1_issue_valid", 64'(issue_valid), 64'(1));
    checkOutput("tp1_issue_vj", 64'(issue_vj), 64'(5));
    checkOutput("tp1_issue_vk", 64'(issue_vk), 64'(9));
    checkOutput("tp1_issue_tag", 64'(issue_tag), 64'(7));
    issue_ready = 1'b1;
    stepCycle();
    clearInputs();

    // CDB capture completes a waiting operand.
    setAlloc(4'd2, 4'd10, 32'd0, 4'd0, 32'd3);
    stepCycle();
    clearInputs();
    stepCycle();
    setCdb(3, 4'd10, 32'h1234);
    stepCycle();
    clearInputs();
    #2;
    checkOutput("tp2_issue_valid", 64'(issue_valid), 64'(1));
    checkOutput("tp2_issue_vj", 64'(issue_vj), 64'h1234);
    issue_ready = 1'b1;
    stepCycle();
    clearInputs();

    // Same-cycle bypass at allocation.
    setAlloc(4'd3, 4'd0, 32'd1, 4'd8, 32'd0);
    setCdb(0, 4'd8, 32'd42);
    stepCycle();
    clearInputs();
    #2;
    checkOutput("tp3_issue_valid", 64'(issue_valid), 64'(1));
    checkOutput("tp3_issue_vk", 64'(issue_vk), 64'd42);
    issue_ready = 1'b1;
    stepCycle();
    clearInputs();

    // Fill, then free one slot; it becomes allocatable the next cycle.
    for (int k = 0; k < N; k++) begin
      setAlloc(OW'(k + 4), 4'd0, 32'(k), 4'd0, 32'(k + 100));
      stepCycle();
    end
    clearInputs();
    #2;
    checkOutput("tp4_full_ready", 64'(alloc_ready), 64'(0));
    checkOutput("tp4_full_occ", 64'(occupancy), 64'(3));
    issue_ready = 1'b1;
    stepCycle();
    issue_ready = 1'b0;
    #2;
    checkOutput("tp4_after_occ", 64'(occupancy), 64'(2));
    checkOutput("tp4_after_ready", 64'(alloc_ready), 64'(1));
    stepCycle();

    // Flush with two busy entries and an operation presented.
    flush = 1'b1;
    stepCycle();
    clearInputs();
    #2;
    checkOutput("flush_busy_vec", 64'(busy_vec), 64'(0));
    checkOutput("flush_issue_valid", 64'(issue_valid), 64'(0));
    stepCycle();

    // Lock: entry 2 presented and stalled; entry 0 becoming ready must not steal the slot.
    setAlloc(4'd5, 4'd12, 32'd0, 4'd0, 32'd1); stepCycle();
    setAlloc(4'd6, 4'd13, 32'd0, 4'd0, 32'd2); stepCycle();
    setAlloc(4'd7, 4'd0, 32'd3, 4'd0, 32'd4);  stepCycle();
    clearInputs();
    #2 checkOutput("lock_first_tag", 64'(issue_tag), 64'(9));
    stepCycle();
    setCdb(0, 4'd12, 32'hAA);
    stepCycle();
    clearInputs();
    #2;
    checkOutput("lock_hold_tag", 64'(issue_tag), 64'(9));
    checkOutput("lock_hold_valid", 64'(issue_valid), 64'(1));
    issue_ready = 1'b1;
    stepCycle();
    issue_ready = 1'b0;
    #2 checkOutput("lock_next_tag", 64'(issue_tag), 64'(7));
    issue_ready = 1'b1;
    stepCycle();
    clearInputs();
    flush = 1'b1;
    stepCycle();
    clearInputs();

    // Age: entry 2 allocated before entry 0, both become ready together.
    setAlloc(4'd1, 4'd12, 32'd0, 4'd0, 32'd1); stepCycle();
    setAlloc(4'd2, 4'd13, 32'd0, 4'd0, 32'd2); stepCycle();
    setAlloc(4'd3, 4'd14, 32'd0, 4'd0, 32'd3); stepCycle();
    clearInputs();
    setCdb(0, 4'd12, 32'h11);
    issue_ready = 1'b1;
    stepCycle();
    clearInputs();
    issue_ready = 1'b1;
    stepCycle();
    clearInputs();
    setAlloc(4'd4, 4'd14, 32'd0, 4'd0, 32'd4);
    stepCycle();
    clearInputs();
    setCdb(2, 4'd14, 32'h77);
    stepCycle();
    clearInputs();
    #2;
    checkOutput("age_first_tag", 64'(issue_tag), AGE ? 64'(9) : 64'(7));
    checkOutput("age_first_vj", 64'(issue_vj), 64'h77);
    stepCycle();
    issue_ready = 1'b1;
    stepCycle();
    issue_ready = 1'b0;
    #2 checkOutput("age_second_tag", 64'(issue_tag), AGE ? 64'(7) : 64'(9));
    stepCycle();
    flush = 1'b1;
    stepCycle();
    clearInputs();

    // Asynchronous reset in the middle of a presented operation.
    setAlloc(4'd9, 4'd0, 32'd7, 4'd0, 32'd8);
    stepCycle();
    clearInputs();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy_vec", 64'(busy_vec), 64'(0));
    checkOutput("arst_issue_valid", 64'(issue_valid), 64'(0));
    checkOutput("arst_issue_tag", 64'(issue_tag), 64'(0));
    checkOutput("arst_occupancy", 64'(occupancy), 64'(0));
    checkOutput("arst_alloc_tag", 64'(alloc_tag), 64'(7));
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int n = 0; n < 1500; n++) begin
      applyStimulus();
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
